// File: rtl/lvds_pkg.sv
// rtl/lvds_pkg.sv - shared types and constants for the LVDS alignment controller
package lvds_pkg;

    localparam int NUM_LANES = 8;
    localparam int SAMPLE_W  = 14;
    localparam logic [SAMPLE_W-1:0] EXP_PATTERN_DEF = 14'h2A5C;

    // Lane slot order inside lane_data, A0 in the least significant sample
    typedef enum logic [2:0] {
        LANE_A0, LANE_A1, LANE_A2, LANE_A3,
        LANE_B0, LANE_B1, LANE_B2, LANE_B3
    } lane_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WAIT_LOCK, ST_SETTLE, ST_CHECK, ST_EVAL,
        ST_STEP, ST_DECIDE, ST_DONE, ST_FAIL
    } state_e;

endpackage

// File: rtl/lvds_lane_checker.sv
// rtl/lvds_lane_checker.sv - per-lane pattern comparators and match-run counter
module lvds_lane_checker
    import lvds_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] EXP_PATTERN = EXP_PATTERN_DEF,
    parameter int                  CHECK_LEN   = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [NUM_LANES*SAMPLE_W-1:0] lane_data,
    output logic                          pass,
    output logic                          fail,
    output logic [NUM_LANES-1:0]          mismatch
);

    localparam int CW = $clog2(CHECK_LEN + 1);

    logic [CW-1:0] run_cnt;

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mismatch[i] = (lane_data[i*SAMPLE_W +: SAMPLE_W] != EXP_PATTERN);
        end
    end

    assign fail = enable && (|mismatch);
    assign pass = enable && !(|mismatch) && (run_cnt == CW'(CHECK_LEN - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_cnt <= '0;
        end else if (!enable || (|mismatch) || pass) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lvds_align_ctrl.sv
// rtl/lvds_align_ctrl.sv - PLL phase sweep, widest passing window search and centre parking
module lvds_align_ctrl
    import lvds_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] EXP_PATTERN   = EXP_PATTERN_DEF,
    parameter int                  NUM_STEPS     = 32,
    parameter int                  SETTLE_CYCLES = 64,
    parameter int                  CHECK_LEN     = 256,
    parameter int                  STEP_TIMEOUT  = 1024,
    parameter int                  MIN_WINDOW    = 4
) (
    input  logic                          LVDS_PARALLEL_CLK,
    input  logic                          rstn,
    input  logic                          start,
    input  logic                          pll_locked,
    input  logic [NUM_LANES*SAMPLE_W-1:0] lane_data,
    output logic                          phase_en,
    output logic                          phase_updn,
    input  logic                          phase_done,
    output logic                          busy,
    output logic                          aligned,
    output logic                          fail,
    output logic [4:0]                    best_start,
    output logic [5:0]                    best_len,
    output logic [NUM_LANES-1:0]          err_lanes
);

    localparam int         SCW       = $clog2(SETTLE_CYCLES);
    localparam int         TOW       = $clog2(STEP_TIMEOUT);
    localparam logic [4:0] LAST_STEP = 5'(NUM_STEPS - 1);

    state_e               state, state_nxt;
    logic [4:0]           step_idx, run_start, cur_start;
    logic [5:0]           run_len, cur_len, park_left, target;
    logic [SCW-1:0]       settle_cnt;
    logic [TOW-1:0]       step_timer;
    logic                 park, req_off, last_pass, lock_lost, win_close;
    logic                 chk_pass, chk_fail;
    logic [NUM_LANES-1:0] chk_mismatch;

    lvds_lane_checker #(
        .EXP_PATTERN (EXP_PATTERN),
        .CHECK_LEN   (CHECK_LEN)
    ) u_checker (
        .clk       (LVDS_PARALLEL_CLK),
        .rstn      (rstn),
        .enable    (state == ST_CHECK),
        .lane_data (lane_data),
        .pass      (chk_pass),
        .fail      (chk_fail),
        .mismatch  (chk_mismatch)
    );

    assign lock_lost = !pll_locked &&
                       (state inside {ST_SETTLE, ST_CHECK, ST_EVAL, ST_STEP, ST_DECIDE});
    // Windows never wrap past index 0, so the centre fits without modulo
    assign target    = {1'b0, best_start} + {1'b0, best_len[5:1]};
    assign cur_len   = last_pass ? run_len + 6'd1 : run_len;
    assign cur_start = (last_pass && run_len == 6'd0) ? step_idx : run_start;
    assign win_close = !last_pass || (step_idx == LAST_STEP);

    always_ff @(posedge LVDS_PARALLEL_CLK or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (pll_locked) state_nxt = ST_SETTLE;
            ST_SETTLE:    if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) state_nxt = ST_CHECK;
            ST_CHECK:     if (chk_pass || chk_fail) state_nxt = ST_EVAL;
            ST_EVAL:      state_nxt = ST_STEP;
            ST_STEP: begin
                if (phase_done) begin
                    if (park) begin
                        if (park_left == 6'd1) state_nxt = ST_DONE;
                    end else if (step_idx == LAST_STEP) begin
                        state_nxt = ST_DECIDE;
                    end else begin
                        state_nxt = ST_SETTLE;
                    end
                end else if (phase_en && step_timer == TOW'(STEP_TIMEOUT - 1)) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_DECIDE: begin
                if (best_len < 6'(MIN_WINDOW)) state_nxt = ST_FAIL;
                else if (target == 6'd0)       state_nxt = ST_DONE;
                else                           state_nxt = ST_STEP;
            end
            default:      state_nxt = ST_IDLE;
        endcase
        if (lock_lost) state_nxt = ST_WAIT_LOCK;
    end

    always_comb begin
        phase_en   = (state == ST_STEP) && !req_off;
        phase_updn = 1'b1;
        busy       = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
    end

    always_ff @(posedge LVDS_PARALLEL_CLK or negedge rstn) begin
        if (!rstn) begin
            step_idx   <= '0;
            run_start  <= '0;
            run_len    <= '0;
            park_left  <= '0;
            settle_cnt <= '0;
            step_timer <= '0;
            park       <= 1'b0;
            req_off    <= 1'b0;
            last_pass  <= 1'b0;
            aligned    <= 1'b0;
            fail       <= 1'b0;
            best_start <= '0;
            best_len   <= '0;
            err_lanes  <= '0;
        end else begin
            req_off    <= 1'b0;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            step_timer <= (state == ST_STEP && phase_en && !phase_done) ? step_timer + 1'b1 : '0;
            case (state)
                ST_IDLE: if (start) begin
                    aligned    <= 1'b0;
                    fail       <= 1'b0;
                    best_start <= '0;
                    best_len   <= '0;
                    err_lanes  <= '0;
                    run_start  <= '0;
                    run_len    <= '0;
                    step_idx   <= '0;
                    park       <= 1'b0;
                end
                ST_CHECK: begin
                    if (chk_fail) begin
                        err_lanes <= err_lanes | chk_mismatch;
                        last_pass <= 1'b0;
                    end else if (chk_pass) begin
                        last_pass <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    run_start <= cur_start;
                    run_len   <= last_pass ? cur_len : 6'd0;
                    if (win_close && cur_len > best_len) begin
                        best_start <= cur_start;
                        best_len   <= cur_len;
                    end
                end
                ST_STEP: if (phase_done) begin
                    step_idx <= (step_idx == LAST_STEP) ? 5'd0 : step_idx + 5'd1;
                    req_off  <= 1'b1;
                    if (park) park_left <= park_left - 6'd1;
                end
                ST_DECIDE: begin
                    park      <= 1'b1;
                    park_left <= target;
                end
                ST_DONE: aligned <= 1'b1;
                ST_FAIL: fail    <= 1'b1;
                default: ;
            endcase
            if (lock_lost) begin
                step_idx   <= '0;
                run_start  <= '0;
                run_len    <= '0;
                best_start <= '0;
                best_len   <= '0;
                err_lanes  <= '0;
                park       <= 1'b0;
                park_left  <= '0;
                last_pass  <= 1'b0;
            end
        end
    end

endmodule
